// File: rtl/turn_executor.sv
// Turn-trigger responder: accepts left/right/back requests and drives timed
// steering levels, holding is_turning through a chassis settle period.
module turn_executor #(
   parameter int unsigned TURN_90_CYCLES  = 450,
   parameter int unsigned TURN_180_CYCLES = 900,
   parameter int unsigned SETTLE_CYCLES   = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       trigger_turn_left,
   input  logic       trigger_turn_right,
   input  logic       trigger_turn_back,
   output logic       turn_left,
   output logic       turn_right,
   output logic       is_turning,
   output logic [1:0] turn_kind
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TURN   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [1:0] KIND_NONE  = 2'b00;
   localparam logic [1:0] KIND_LEFT  = 2'b01;
   localparam logic [1:0] KIND_RIGHT = 2'b10;
   localparam logic [1:0] KIND_BACK  = 2'b11;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_cnt;
   logic [31:0] w_cnt_nxt;
   logic [31:0] w_len_m1;
   logic [1:0]  r_kind;
   logic [1:0]  w_kind_nxt;
   logic        r_armed;
   logic        w_armed_nxt;
   logic        w_any_trig;

   assign w_any_trig = trigger_turn_left | trigger_turn_right | trigger_turn_back;
   assign w_len_m1   = (r_kind == KIND_BACK) ? 32'(TURN_180_CYCLES - 1)
                                             : 32'(TURN_90_CYCLES - 1);

   // Triggers are levels held well past turn acceptance; armed only re-sets
   // once every trigger has been seen low, so one held request = one turn.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 32'd1;
      w_kind_nxt  = r_kind;
      w_armed_nxt = r_armed;
      if (!w_any_trig) begin
         w_armed_nxt = 1'b1;
      end
      if (!enable) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_kind_nxt  = KIND_NONE;
         w_armed_nxt = r_armed;
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt_nxt = '0;
               if (r_armed && w_any_trig) begin
                  w_state_nxt = TURN;
                  w_armed_nxt = 1'b0;
                  if (trigger_turn_back)      w_kind_nxt = KIND_BACK;
                  else if (trigger_turn_left) w_kind_nxt = KIND_LEFT;
                  else                        w_kind_nxt = KIND_RIGHT;
               end
            end
            TURN: begin
               if (r_cnt == w_len_m1) begin
                  w_state_nxt = SETTLE;
                  w_cnt_nxt   = '0;
               end
            end
            SETTLE: begin
               if (r_cnt == 32'(SETTLE_CYCLES - 1)) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_kind_nxt  = KIND_NONE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_kind_nxt  = KIND_NONE;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state decode so they change on the
   // same edge as the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_kind     <= KIND_NONE;
         r_armed    <= 1'b1;
         turn_left  <= 1'b0;
         turn_right <= 1'b0;
         is_turning <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_kind     <= w_kind_nxt;
         r_armed    <= w_armed_nxt;
         turn_left  <= (w_state_nxt == TURN) && w_kind_nxt[0];
         turn_right <= (w_state_nxt == TURN) && (w_kind_nxt == KIND_RIGHT);
         is_turning <= (w_state_nxt != IDLE);
      end
   end

   assign turn_kind = r_kind;

endmodule

// File: tb/tb_turn_executor.sv
// Directed bench for turn_executor: table of single-turn vectors plus
// hand-written abort, re-arm and busy-ignore sequences.
module tb_turn_executor;

   localparam int T90 = 10;
   localparam int T180 = 20;
   localparam int SET = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic       trigger_turn_left = 1'b0;
   logic       trigger_turn_right = 1'b0;
   logic       trigger_turn_back = 1'b0;
   logic       turn_left;
   logic       turn_right;
   logic       is_turning;
   logic [1:0] turn_kind;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   turn_executor #(
      .TURN_90_CYCLES (T90),
      .TURN_180_CYCLES(T180),
      .SETTLE_CYCLES  (SET)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .trigger_turn_left (trigger_turn_left),
      .trigger_turn_right(trigger_turn_right),
      .trigger_turn_back (trigger_turn_back),
      .turn_left         (turn_left),
      .turn_right        (turn_right),
      .is_turning        (is_turning),
      .turn_kind         (turn_kind)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       l;
      logic       r;
      logic       b;
      int         trig;
      logic [1:0] kind;
      int         len;
   } vec_t;

   // Expected {turn_left, turn_right, is_turning, turn_kind} at cycle c for a
   // turn accepted at edge s.
   function automatic logic [4:0] exp_at(int c, int s, int len, logic [1:0] kind);
      logic st;
      logic it;
      st = (c >= s) && (c < s + len);
      it = (c >= s) && (c < s + len + SET);
      return {st && (kind != 2'b10), st && (kind == 2'b10), it, it ? kind : 2'b00};
   endfunction

   task automatic cmp(string name, logic [4:0] exp);
      logic [4:0] act;
      act = {turn_left, turn_right, is_turning, turn_kind};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got {tl,tr,it,kind}=%b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic step(string name, logic [4:0] exp);
      @(posedge clk);
      @(negedge clk);
      cmp(name, exp);
   endtask

   task automatic set_trig(logic l, logic r, logic b);
      trigger_turn_left  = l;
      trigger_turn_right = r;
      trigger_turn_back  = b;
   endtask

   task automatic idle_gap(string name, int n);
      set_trig(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= n; i++) begin
         cyc = i;
         step(name, 5'b0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{l: 1'b1, r: 1'b0, b: 1'b0, trig: 100, kind: 2'b01, len: T90};
      vecs[1] = '{l: 1'b0, r: 1'b1, b: 1'b1, trig: 30,  kind: 2'b11, len: T180};
      vecs[2] = '{l: 1'b0, r: 1'b1, b: 1'b0, trig: 5,   kind: 2'b10, len: T90};
      vecs[3] = '{l: 1'b1, r: 1'b1, b: 1'b0, trig: 5,   kind: 2'b01, len: T90};
      vecs[4] = '{l: 1'b1, r: 1'b1, b: 1'b1, trig: 2,   kind: 2'b11, len: T180};
      vecs[5] = '{l: 1'b1, r: 1'b0, b: 1'b1, trig: 1,   kind: 2'b11, len: T180};

      // Reset and idle
      @(negedge clk);
      @(negedge clk);
      cmp("reset_hold", 5'b0);
      rst_n = 1'b1;
      idle_gap("idle_after_reset", 20);

      // Table-driven single turns
      for (int v = 0; v < 6; v++) begin
         int n;
         n = ((vecs[v].trig > vecs[v].len + SET) ? vecs[v].trig : vecs[v].len + SET) + 3;
         set_trig(vecs[v].l, vecs[v].r, vecs[v].b);
         for (int c = 1; c <= n; c++) begin
            cyc = c;
            step($sformatf("vec%0d", v), exp_at(c, 1, vecs[v].len, vecs[v].kind));
            if (c == vecs[v].trig) set_trig(1'b0, 1'b0, 1'b0);
         end
         idle_gap($sformatf("vec%0d_gap", v), 2);
      end

      // Re-arm: trigger drops for two cycles mid-turn, rises again and is held
      // past the end of the turn, so a second right turn starts at cycle 15.
      set_trig(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 30; c++) begin
         cyc = c;
         step("rearm", exp_at(c, 1, T90, 2'b10) | exp_at(c, 15, T90, 2'b10));
         if (c == 5)  set_trig(1'b0, 1'b0, 1'b0);
         if (c == 7)  set_trig(1'b0, 1'b1, 1'b0);
         if (c == 20) set_trig(1'b0, 1'b0, 1'b0);
      end
      idle_gap("rearm_gap", 2);

      // Enable abort at cycle 5 of a left turn
      set_trig(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         cyc = c;
         step("enable_abort", (c <= 5) ? exp_at(c, 1, T90, 2'b01) : 5'b0);
         if (c == 3) set_trig(1'b0, 1'b0, 1'b0);
         if (c == 5) enable = 1'b0;
         if (c == 8) enable = 1'b1;
      end
      idle_gap("enable_gap", 2);

      // Asynchronous reset at cycle 7 of a left turn
      set_trig(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         cyc = c;
         step("rst_abort", exp_at(c, 1, T90, 2'b01));
         if (c == 3) set_trig(1'b0, 1'b0, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1 cmp("rst_async", 5'b0);
      @(negedge clk);
      cmp("rst_held", 5'b0);
      rst_n = 1'b1;
      idle_gap("rst_gap", 3);

      // Back pulse during a left turn is ignored
      set_trig(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 25; c++) begin
         cyc = c;
         step("busy_ignore", exp_at(c, 1, T90, 2'b01));
         if (c == 2) set_trig(1'b0, 1'b0, 1'b0);
         if (c == 4) set_trig(1'b0, 1'b0, 1'b1);
         if (c == 5) set_trig(1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/turn_executor.md
Name: turn_executor

Overview:
- Responder side of the turn-trigger interface: accepts trigger_turn_left / trigger_turn_right / trigger_turn_back requests from the semi-auto driving controller.
- Executes the requested turn by driving timed turn_left / turn_right steering levels to the motor/steering logic.
- Reports is_turning so the controller can hold in its TURNING state until the manoeuvre completes.
- Runs in the 500 Hz control clock domain.

Parameters:
- TURN_90_CYCLES, 450, clk cycles a steering output is held for a left or right turn (0.9 s at 500 Hz); must be >= 1
- TURN_180_CYCLES, 900, clk cycles the steering output is held for a turn-back (1.8 s); must be >= 1
- SETTLE_CYCLES, 25, clk cycles after steering drops during which is_turning stays high (chassis settle); must be >= 1

Ports:
- clk  input  1  control clock, 500 Hz; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  block enable; low forces idle synchronously
- trigger_turn_left  input  1  request 90-degree left turn (level, typically held ~100 cycles by initiator)
- trigger_turn_right  input  1  request 90-degree right turn
- trigger_turn_back  input  1  request 180-degree turn
- turn_left  output  1  steering command, left
- turn_right  output  1  steering command, right
- is_turning  output  1  high from request acceptance until settle period ends
- turn_kind  output  2  manoeuvre being executed: 00 none, 01 left, 10 right, 11 back

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state IDLE
  - turn_left = turn_right = is_turning = 0
  - turn_kind = 00
  - counter = 0
  - armed = 1
- States:
  - IDLE: outputs 0.
  - TURN: steering output high, is_turning = 1.
  - SETTLE: steering outputs 0, is_turning = 1, turn_kind held.
- Arming (edge-safe acceptance):
  - A trigger is accepted only while armed = 1.
  - Acceptance clears armed.
  - armed sets again on any clock where all three triggers are low.
  - Net effect: a trigger held across the end of a turn never causes a second turn.
- IDLE -> TURN:
  - Condition: enable = 1, armed = 1, and any trigger is high at the rising edge.
  - Latency: steering and is_turning are high from that same edge, visible the cycle after the trigger is first sampled high.
  - This guarantees is_turning rises long before the initiator's 100-cycle trigger window ends.
- Priority on simultaneous triggers: back > left > right.
- Turn direction and length:
  - Back: drives turn_left for TURN_180_CYCLES, turn_kind = 11.
  - Left: drives turn_left for TURN_90_CYCLES, turn_kind = 01.
  - Right: drives turn_right for TURN_90_CYCLES, turn_kind = 10.
- Counter: 32-bit, cleared on entry to TURN and SETTLE, increments each cycle.
- TURN -> SETTLE: when counter == length-1, so the steering output is high for exactly length cycles.
- SETTLE -> IDLE: when counter == SETTLE_CYCLES-1; is_turning falls and turn_kind returns to 00 on that edge.
- Total is_turning high time: length + SETTLE_CYCLES cycles.
- Triggers arriving during TURN or SETTLE are ignored; they are only used for arming.
- turn_left and turn_right are never high simultaneously.
- enable low in any state: next edge forces IDLE, all outputs 0, counter 0. armed is left unchanged.
- rst_n low mid-turn: all outputs drop immediately (asynchronous).

Test Plan:
- Bench parameters: TURN_90=10, TURN_180=20, SETTLE=3.
- Reset/idle: rst_n low then high with no triggers -> all outputs 0, turn_kind=00 for 20 cycles.
- Left turn: trigger_turn_left high for 100 cycles from cycle 0 ->
  - turn_left high cycles 1-10.
  - is_turning high cycles 1-13.
  - turn_kind=01 over the same window.
  - No second turn although the trigger is still high at cycle 14.
  - turn_right never high.
- Back turn and priority: trigger_turn_back and trigger_turn_right high together ->
  - turn_left high 20 cycles, turn_kind=11, is_turning high 23 cycles.
  - turn_right stays 0.
- Re-arm: right trigger 5 cycles, low 2 cycles during the turn, high again after IDLE -> second right turn of 10 cycles executes.
  - Control: a trigger held continuously yields only one turn.
- Abort:
  - enable low at cycle 5 of a left turn -> next edge all outputs 0, state IDLE.
  - rst_n low at cycle 7 -> outputs 0 without waiting for a clk edge.
- Ignore during busy: left turn in progress, pulse trigger_turn_back at cycle 4 -> turn completes unchanged (10 + 3 cycles), no back turn follows.
